// File: rtl/mc_core_pkg.sv
// Shared opcodes, sequencer states and memory-request encodings for the mc_core_p multicycle core.
package mc_core_pkg;

   localparam logic [2:0] OP_LD   = 3'd0;
   localparam logic [2:0] OP_ST   = 3'd1;
   localparam logic [2:0] OP_NOP  = 3'd2;
   localparam logic [2:0] OP_SET  = 3'd3;
   localparam logic [2:0] OP_ADD  = 3'd4;
   localparam logic [2:0] OP_BNZ  = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd6;
   localparam logic [2:0] OP_ILL  = 3'd7;

   localparam logic [1:0] RW_IDLE = 2'd0;
   localparam logic [1:0] RW_RD   = 2'd1;
   localparam logic [1:0] RW_WT   = 2'd2;

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      EXE   = 3'd1,
      MEM   = 3'd2,
      HALT  = 3'd3,
      ERR   = 3'd4
   } state_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) return v;
      else return v + 32'd1;
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// NREG x DATA_W register file: one synchronous write port, one combinational read port, cleared on reset.
module mc_regfile
   import mc_core_pkg::*;
#(
   parameter int unsigned DATA_W = 32'd16,
   parameter int unsigned NREG   = 32'd4,
   localparam int unsigned REG_AW = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] regs_r [NREG];

   // register storage with synchronous clear
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) regs_r[i] <= '0;
      end else if (we) begin
         regs_r[waddr] <= wdata;
      end
   end

   assign rdata = regs_r[raddr];

endmodule

// File: rtl/mc_core_p.sv
// Multicycle FETCH/EXE/MEM/HALT/ERR core with memory-wait timeout.
// Optional MC_CORE_PERF_CNT_EN adds saturating retired/stall_cyc counters.
module mc_core_p
   import mc_core_pkg::*;
#(
   parameter int unsigned DATA_W      = 32'd16,
   parameter int unsigned ADDR_W      = 32'd16,
   parameter int unsigned NREG        = 32'd4,
   parameter int unsigned PC_W        = 32'd8,
   parameter int unsigned IMM_W       = 32'd16,
   parameter int unsigned MEM_TIMEOUT = 32'd255,
   localparam int unsigned REG_AW     = $clog2(NREG),
   localparam int unsigned INS_W      = 32'd3 + REG_AW + IMM_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [INS_W-1:0]  ins,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] data,
   output logic              halted,
   output logic              error,
   output logic [1:0]        mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rd_done,
   input  logic              mem_wt_done,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef MC_CORE_PERF_CNT_EN
   ,
   output logic [31:0]       retired,
   output logic [31:0]       stall_cyc
`endif
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT > 32'd1) ? $clog2(MEM_TIMEOUT + 32'd1) : 32'd1;

   state_t              state_r, state_nxt_s;
   logic [INS_W-1:0]    ir_r, ir_nxt_s;
   logic [PC_W-1:0]     pc_r, pc_nxt_s;
   logic [DATA_W-1:0]   data_r, data_nxt_s;
   logic [1:0]          mem_rw_r, mem_rw_nxt_s;
   logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nxt_s;
   logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_nxt_s;
   logic [WAIT_W-1:0]   wait_r, wait_nxt_s, wait_inc_s;
   logic                halted_r, error_r;

   logic [2:0]          op_s;
   logic [REG_AW-1:0]   rd_s;
   logic [IMM_W-1:0]    imm_s;
   logic [DATA_W-1:0]   imm_data_s, rf_rdata_s, rf_wdata_s;
   logic                rf_we_s, done_s, timeout_s;

   assign op_s       = ir_r[INS_W-1 -: 3];
   assign rd_s       = ir_r[IMM_W +: REG_AW];
   assign imm_s      = ir_r[IMM_W-1:0];
   assign imm_data_s = DATA_W'(imm_s);
   assign done_s     = (op_s == OP_LD) ? mem_rd_done : mem_wt_done;
   assign wait_inc_s = wait_r + WAIT_W'(1'b1);
   // expiry only counts when the matching done is absent; done on the same cycle wins
   assign timeout_s  = (MEM_TIMEOUT != 32'd0) && (wait_inc_s == WAIT_W'(MEM_TIMEOUT));

   mc_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
      .clk   (clk),
      .reset (reset),
      .we    (rf_we_s),
      .waddr (rd_s),
      .wdata (rf_wdata_s),
      .raddr (rd_s),
      .rdata (rf_rdata_s)
   );

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= FETCH;
         ir_r        <= '0;
         pc_r        <= '0;
         data_r      <= '0;
         mem_rw_r    <= RW_IDLE;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         wait_r      <= '0;
         halted_r    <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         ir_r        <= ir_nxt_s;
         pc_r        <= pc_nxt_s;
         data_r      <= data_nxt_s;
         mem_rw_r    <= mem_rw_nxt_s;
         mem_addr_r  <= mem_addr_nxt_s;
         mem_wdata_r <= mem_wdata_nxt_s;
         wait_r      <= wait_nxt_s;
         halted_r    <= (state_nxt_s == HALT);
         error_r     <= (state_nxt_s == ERR);
      end
   end

   // next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         FETCH: state_nxt_s = EXE;
         EXE: begin
            case (op_s)
               OP_LD, OP_ST:                    state_nxt_s = MEM;
               OP_NOP, OP_SET, OP_ADD, OP_BNZ:  state_nxt_s = FETCH;
               OP_HALT:                         state_nxt_s = HALT;
               default:                         state_nxt_s = ERR;
            endcase
         end
         MEM: begin
            if (done_s)         state_nxt_s = FETCH;
            else if (timeout_s) state_nxt_s = ERR;
            else                state_nxt_s = MEM;
         end
         HALT:    state_nxt_s = HALT;
         ERR:     state_nxt_s = ERR;
         default: state_nxt_s = ERR;
      endcase
   end

   // datapath next values and register-file write
   always_comb begin
      ir_nxt_s        = ir_r;
      pc_nxt_s        = pc_r;
      data_nxt_s      = data_r;
      mem_rw_nxt_s    = mem_rw_r;
      mem_addr_nxt_s  = mem_addr_r;
      mem_wdata_nxt_s = mem_wdata_r;
      wait_nxt_s      = wait_r;
      rf_we_s         = 1'b0;
      rf_wdata_s      = '0;
      case (state_r)
         FETCH: begin
            ir_nxt_s     = ins;
            pc_nxt_s     = pc_r + PC_W'(1'b1);
            mem_rw_nxt_s = RW_IDLE;
         end
         EXE: begin
            case (op_s)
               OP_LD: begin
                  mem_rw_nxt_s   = RW_RD;
                  mem_addr_nxt_s = ADDR_W'(imm_s);
                  wait_nxt_s     = '0;
               end
               OP_ST: begin
                  mem_rw_nxt_s    = RW_WT;
                  mem_addr_nxt_s  = ADDR_W'(imm_s);
                  mem_wdata_nxt_s = rf_rdata_s;
                  wait_nxt_s      = '0;
               end
               OP_SET: begin
                  rf_we_s    = 1'b1;
                  rf_wdata_s = imm_data_s;
                  data_nxt_s = imm_data_s;
               end
               OP_ADD: begin
                  rf_we_s    = 1'b1;
                  rf_wdata_s = rf_rdata_s + imm_data_s;
                  data_nxt_s = rf_rdata_s + imm_data_s;
               end
               OP_BNZ: begin
                  if (rf_rdata_s != {DATA_W{1'b0}}) pc_nxt_s = PC_W'(imm_s);
                  else                              pc_nxt_s = pc_r;
               end
               default: mem_rw_nxt_s = RW_IDLE;
            endcase
         end
         MEM: begin
            if (done_s) begin
               mem_rw_nxt_s = RW_IDLE;
               if (op_s == OP_LD) begin
                  rf_we_s    = 1'b1;
                  rf_wdata_s = mem_rdata;
                  data_nxt_s = mem_rdata;
               end else begin
                  rf_we_s = 1'b0;
               end
            end else if (timeout_s) begin
               mem_rw_nxt_s = RW_IDLE;
            end else begin
               wait_nxt_s = wait_inc_s;
            end
         end
         default: mem_rw_nxt_s = RW_IDLE;
      endcase
   end

   assign pc        = pc_r;
   assign data      = data_r;
   assign halted    = halted_r;
   assign error     = error_r;
   assign mem_rw    = mem_rw_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;

`ifdef MC_CORE_PERF_CNT_EN
   logic [31:0] retired_r, stall_cyc_r;
   logic        retire_s, stall_s;

   assign retire_s = ((state_r == EXE) || (state_r == MEM)) && (state_nxt_s == FETCH);
   assign stall_s  = (state_r == MEM) && !done_s;

   // saturating performance counters
   always_ff @(posedge clk) begin
      if (reset) begin
         retired_r   <= 32'd0;
         stall_cyc_r <= 32'd0;
      end else begin
         if (retire_s) retired_r   <= sat_inc32(retired_r);
         if (stall_s)  stall_cyc_r <= sat_inc32(stall_cyc_r);
      end
   end

   assign retired   = retired_r;
   assign stall_cyc = stall_cyc_r;
`endif

endmodule

// File: tb/tb_mc_core_p.sv
// Directed, table-driven bench for mc_core_p (default 255-cycle timeout plus a 4-cycle timeout instance).
module tb_mc_core_p;

   localparam logic [2:0] T_LD = 3'd0, T_ST = 3'd1, T_NOP = 3'd2, T_SET = 3'd3,
                          T_ADD = 3'd4, T_BNZ = 3'd5, T_HALT = 3'd6, T_ILL = 3'd7;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [20:0] prog   [256];
   logic [20:0] prog_t [256];

   logic [20:0] ins, ins_t;
   logic [7:0]  pc, pc_t;
   logic [15:0] data, data_t, mem_addr, mem_addr_t, mem_wdata, mem_wdata_t;
   logic        halted, halted_t, error, error_t;
   logic [1:0]  mem_rw, mem_rw_t;
   logic        rd_done = 1'b0, wt_done = 1'b0, rd_done_t = 1'b0, wt_done_t = 1'b0;
   logic [15:0] rdata = 16'h0000, rdata_t = 16'h0000;
`ifdef MC_CORE_PERF_CNT_EN
   logic [31:0] retired, stall_cyc, retired_t, stall_cyc_t;
`endif

   int n_chk = 0;
   int n_fail = 0;

   assign ins   = prog[pc];
   assign ins_t = prog_t[pc_t];

   always #5 clk = ~clk;

   mc_core_p dut (
      .clk(clk), .reset(reset), .ins(ins), .pc(pc), .data(data), .halted(halted), .error(error),
      .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rd_done(rd_done), .mem_wt_done(wt_done), .mem_rdata(rdata)
`ifdef MC_CORE_PERF_CNT_EN
      , .retired(retired), .stall_cyc(stall_cyc)
`endif
   );

   mc_core_p #(.MEM_TIMEOUT(32'd4)) dut_t (
      .clk(clk), .reset(reset), .ins(ins_t), .pc(pc_t), .data(data_t), .halted(halted_t), .error(error_t),
      .mem_rw(mem_rw_t), .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t),
      .mem_rd_done(rd_done_t), .mem_wt_done(wt_done_t), .mem_rdata(rdata_t)
`ifdef MC_CORE_PERF_CNT_EN
      , .retired(retired_t), .stall_cyc(stall_cyc_t)
`endif
   );

   typedef struct packed {
      logic [2:0]  op;
      logic [1:0]  rd;
      logic [15:0] init;
      logic [15:0] imm;
      logic [15:0] exp_data;
      logic [7:0]  exp_pc;
      logic        exp_halt;
      logic        exp_err;
   } vec_t;

   vec_t vecs [9];

   function automatic logic [20:0] enc(input logic [2:0] op, input logic [1:0] rd, input logic [15:0] imm);
      return {op, rd, imm};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic clear_progs();
      for (int i = 0; i < 256; i++) begin
         prog[i]   = enc(T_HALT, 2'd0, 16'h0000);
         prog_t[i] = enc(T_HALT, 2'd0, 16'h0000);
      end
   endtask

   task automatic run_until_stop(input int budget, input string name);
      int n = 0;
      while (!(halted || error) && n < budget) begin
         step(1);
         n++;
      end
      n_chk++;
      if (!(halted || error)) begin
         n_fail++;
         $display("FAIL %s: no halt/error within %0d cycles", name, budget);
      end
   endtask

   initial begin
      int add_cnt;
      logic [7:0] prev_pc;

      vecs[0] = '{T_SET,  2'd1, 16'h0000, 16'h1234, 16'h1234, 8'h03, 1'b1, 1'b0};
      vecs[1] = '{T_ADD,  2'd0, 16'h0003, 16'hFFFF, 16'h0002, 8'h03, 1'b1, 1'b0};
      vecs[2] = '{T_ADD,  2'd2, 16'h8000, 16'h8000, 16'h0000, 8'h03, 1'b1, 1'b0};
      vecs[3] = '{T_ADD,  2'd1, 16'hFFFF, 16'h0001, 16'h0000, 8'h03, 1'b1, 1'b0};
      vecs[4] = '{T_BNZ,  2'd3, 16'h0005, 16'h0040, 16'h0005, 8'h41, 1'b1, 1'b0};
      vecs[5] = '{T_BNZ,  2'd3, 16'h0000, 16'h0040, 16'h0000, 8'h03, 1'b1, 1'b0};
      vecs[6] = '{T_NOP,  2'd0, 16'hABCD, 16'h5555, 16'hABCD, 8'h03, 1'b1, 1'b0};
      vecs[7] = '{T_HALT, 2'd2, 16'h0007, 16'h0000, 16'h0007, 8'h02, 1'b1, 1'b0};
      vecs[8] = '{T_ILL,  2'd1, 16'h0009, 16'h0000, 16'h0009, 8'h02, 1'b0, 1'b1};

      // Reset state and test 1 timing
      clear_progs();
      prog[0] = enc(T_SET, 2'd1, 16'h1234);
      prog[1] = enc(T_HALT, 2'd0, 16'h0000);
      reset = 1'b1;
      step(2);
      chk("rst_pc", pc, 8'h00);
      chk("rst_data", data, 16'h0000);
      chk("rst_rw", mem_rw, 2'd0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_error", error, 1'b0);
      reset = 1'b0;
      step(1);
      chk("t1_data_c1", data, 16'h0000);
      step(1);
      chk("t1_data_c2", data, 16'h1234);
      step(1);
      chk("t1_halted_c3", halted, 1'b0);
      step(1);
      chk("t1_halted_c4", halted, 1'b1);
      chk("t1_pc_c4", pc, 8'h02);
      step(2);
      chk("t1_pc_frozen", pc, 8'h02);

      // Single-instruction vectors: SET rd,init ; <op> ; HALT
      for (int v = 0; v < 9; v++) begin
         clear_progs();
         prog[0] = enc(T_SET, vecs[v].rd, vecs[v].init);
         prog[1] = enc(vecs[v].op, vecs[v].rd, vecs[v].imm);
         do_reset();
         run_until_stop(40, $sformatf("vec%0d_stop", v));
         step(1);
         chk($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
         chk($sformatf("vec%0d_pc", v), pc, vecs[v].exp_pc);
         chk($sformatf("vec%0d_halted", v), halted, vecs[v].exp_halt);
         chk($sformatf("vec%0d_error", v), error, vecs[v].exp_err);
         chk($sformatf("vec%0d_rw", v), mem_rw, 2'd0);
      end

      // Test 2: store with wt_done in the third MEM cycle, stray rd_done ignored
      clear_progs();
      prog[0] = enc(T_SET, 2'd0, 16'h0003);
      prog[1] = enc(T_ADD, 2'd0, 16'hFFFF);
      prog[2] = enc(T_ST, 2'd0, 16'h0010);
      do_reset();
      step(6);
      chk("t2_rw_wt1", mem_rw, 2'd2);
      chk("t2_addr", mem_addr, 16'h0010);
      chk("t2_wdata", mem_wdata, 16'h0002);
      rd_done = 1'b1;
      step(1);
      rd_done = 1'b0;
      chk("t2_rw_wt2", mem_rw, 2'd2);
      step(1);
      chk("t2_rw_wt3", mem_rw, 2'd2);
      wt_done = 1'b1;
      step(1);
      wt_done = 1'b0;
      chk("t2_rw_idle", mem_rw, 2'd0);
      run_until_stop(20, "t2_stop");
      chk("t2_pc_end", pc, 8'h04);

      // Test 3: load with rd_done after 5 MEM cycles, stray wt_done ignored
      clear_progs();
      prog[0] = enc(T_LD, 2'd2, 16'h0020);
      prog[1] = enc(T_ST, 2'd2, 16'h0040);
      do_reset();
      step(2);
      chk("t3_rw_rd", mem_rw, 2'd1);
      chk("t3_addr", mem_addr, 16'h0020);
      step(1);
      wt_done = 1'b1;
      step(1);
      wt_done = 1'b0;
      chk("t3_rw_hold", mem_rw, 2'd1);
      step(2);
      rd_done = 1'b1;
      rdata = 16'hBEEF;
      step(1);
      rd_done = 1'b0;
      rdata = 16'h0000;
      chk("t3_data", data, 16'hBEEF);
      chk("t3_rw_idle", mem_rw, 2'd0);
      chk("t3_pc_before_fetch", pc, 8'h01);
      step(1);
      chk("t3_pc_fetch", pc, 8'h02);
      step(1);
      chk("t3_reg2_via_st", mem_wdata, 16'hBEEF);
      wt_done = 1'b1;
      step(1);
      wt_done = 1'b0;
      run_until_stop(20, "t3_stop");

      // Test 4: BNZ loop runs ADD exactly twice
      clear_progs();
      prog[0] = enc(T_SET, 2'd0, 16'h0002);
      prog[1] = enc(T_ADD, 2'd0, 16'hFFFF);
      prog[2] = enc(T_BNZ, 2'd0, 16'h0001);
      do_reset();
      add_cnt = 0;
      prev_pc = pc;
      for (int c = 0; c < 60 && !halted; c++) begin
         step(1);
         if (pc == 8'h02 && prev_pc != 8'h02) add_cnt++;
         prev_pc = pc;
      end
      chk("t4_add_count", add_cnt, 32'd2);
      chk("t4_halted", halted, 1'b1);
      chk("t4_pc_end", pc, 8'h04);
      chk("t4_data", data, 16'h0000);

      // Test 5: 4-cycle timeout, then done exactly on the expiry cycle
      clear_progs();
      prog_t[0] = enc(T_LD, 2'd1, 16'h0005);
      do_reset();
      step(5);
      chk("t5_no_err_c3", error_t, 1'b0);
      chk("t5_rw_rd", mem_rw_t, 2'd1);
      step(1);
      chk("t5_err", error_t, 1'b1);
      chk("t5_rw_idle", mem_rw_t, 2'd0);
      chk("t5_pc", pc_t, 8'h01);
      step(3);
      chk("t5_err_sticky", error_t, 1'b1);
      chk("t5_pc_frozen", pc_t, 8'h01);
      do_reset();
      step(5);
      rd_done_t = 1'b1;
      rdata_t = 16'h55AA;
      step(1);
      rd_done_t = 1'b0;
      rdata_t = 16'h0000;
      chk("t5_edge_no_err", error_t, 1'b0);
      chk("t5_edge_data", data_t, 16'h55AA);
      chk("t5_edge_rw", mem_rw_t, 2'd0);
      step(4);
      chk("t5_edge_halted", halted_t, 1'b1);

      // Test 6: reset mid-MEM, registers cleared, then illegal opcode
      clear_progs();
      prog[0] = enc(T_SET, 2'd3, 16'h0077);
      prog[1] = enc(T_LD, 2'd0, 16'h0020);
      do_reset();
      step(4);
      chk("t6_rw_rd", mem_rw, 2'd1);
      reset = 1'b1;
      step(1);
      chk("t6_rw_idle", mem_rw, 2'd0);
      chk("t6_pc", pc, 8'h00);
      chk("t6_data", data, 16'h0000);
      prog[0] = enc(T_ST, 2'd3, 16'h0030);
      prog[1] = enc(T_ILL, 2'd0, 16'h0000);
      reset = 1'b0;
      step(2);
      chk("t6_rw_wt", mem_rw, 2'd2);
      chk("t6_reg3_cleared", mem_wdata, 16'h0000);
      wt_done = 1'b1;
      step(1);
      wt_done = 1'b0;
      run_until_stop(20, "t6_stop");
      chk("t6_error", error, 1'b1);
      chk("t6_halted", halted, 1'b0);
      chk("t6_pc_end", pc, 8'h02);
      chk("t6_rw_end", mem_rw, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
